// File: rtl/cmos_pair_switch_model.sv
// ---------------------------------------------------------------------------
// cmos_pair_switch_model
//
// Cycle-accurate model of one complementary MOS pair. A PMOS pulls the node
// up to VDD and an NMOS pulls it down to VSS. The 4-valued gate inputs are
// resolved to a 4-valued node value. That value reaches the registered
// output through an inertial delay counted in clock cycles. Used as the
// leaf cell of the sampled-time switch-level simulator.
//
// Value encoding on every value port: 00=0, 01=1, 10=Z, 11=X.
//
// Parameters:
//   RISE_DLY  cycles a new target of 1 must stay stable before out updates
//   FALL_DLY  cycles a new target of 0 must stay stable before out updates
//   ZX_DLY    cycles for a target of Z or X
//   (legal range of each: 1..255)
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst_n   in   1  asynchronous active-low reset
//   pmos_g  in   2  PMOS gate value
//   nmos_g  in   2  NMOS gate value
//   out     out  2  registered node value
//   busy    out  1  high while a target that differs from out is being timed
//   target  out  2  combinational resolved value, for observation
//
// Optional feature macro: CHARGE_HOLD_EN
//   When it is defined, a resolved Z means the node keeps its charge. The
//   target then becomes the 0/1 that out already holds, or X if out is X.
//   As a result, Z never reaches out.
// ---------------------------------------------------------------------------
module cmos_pair_switch_model #(
    parameter logic [7:0] RISE_DLY = 8'd5,
    parameter logic [7:0] FALL_DLY = 8'd5,
    parameter logic [7:0] ZX_DLY   = 8'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pmos_g,
    input  logic [1:0] nmos_g,
    output logic [1:0] out,
    output logic       busy,
    output logic [1:0] target
);

    localparam logic [1:0] V0 = 2'b00;
    localparam logic [1:0] V1 = 2'b01;
    localparam logic [1:0] VZ = 2'b10;
    localparam logic [1:0] VX = 2'b11;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0] out_q,  out_d;
    logic       busy_q, busy_d;
    logic [7:0] cnt_q,  cnt_d;
    logic [1:0] pend_q, pend_d;   // target sampled on the previous edge

    // -----------------------------------------------------------------------
    // Conduction of each device. Z and X on a gate both count as unknown,
    // and these values are exactly the ones with bit 1 set.
    // -----------------------------------------------------------------------
    logic p_on, p_off, n_on, n_off, gate_unk;

    assign p_on     = (pmos_g == V0);
    assign p_off    = (pmos_g == V1);
    assign n_on     = (nmos_g == V1);
    assign n_off    = (nmos_g == V0);
    assign gate_unk = pmos_g[1] | nmos_g[1];

    // -----------------------------------------------------------------------
    // Resolution. There are no weak L/H levels: any unknown conduction
    // gives X, even when the other device is firmly on.
    // -----------------------------------------------------------------------
    logic [1:0] res;

    always_comb begin
        res = VX;
        if (!gate_unk) begin
            if (p_on && n_off)
                res = V1;
            else if (p_off && n_on)
                res = V0;
            else if (p_off && n_off)
                res = VZ;
            else
                res = VX;           // both on: contention
        end
    end

    // -----------------------------------------------------------------------
    // Target value
    // -----------------------------------------------------------------------
    logic [1:0] tgt;

`ifdef CHARGE_HOLD_EN
    // A floating node keeps the charge it holds. Because out is never Z in
    // this build, out_q[1] set means X, and X stays X.
    always_comb begin
        tgt = res;
        if (res == VZ)
            tgt = out_q[1] ? VX : out_q;
    end
`else
    assign tgt = res;
`endif

    // -----------------------------------------------------------------------
    // Delay for the current target
    // -----------------------------------------------------------------------
    logic [7:0] dly;

    always_comb begin
        case (tgt)
            V1:      dly = RISE_DLY;
            V0:      dly = FALL_DLY;
            default: dly = ZX_DLY;
        endcase
    end

    // -----------------------------------------------------------------------
    // Inertial delay.
    // The count restarts at 1 whenever the target differs from the value
    // sampled on the previous edge. Out is committed on the edge where the
    // count reaches the delay. So a target held for D edges lands on the
    // D-th edge, and any shorter pulse is lost. Because the count is cleared
    // at the compare, it can never pass 255.
    // -----------------------------------------------------------------------
    logic [7:0] cnt_nxt;

    assign cnt_nxt = (tgt != pend_q) ? 8'd1 : cnt_q + 8'd1;

    always_comb begin
        out_d  = out_q;
        busy_d = 1'b0;
        cnt_d  = 8'd0;
        pend_d = tgt;
        if (tgt == out_q) begin
            // The target has returned to out, or never left it. Any pending
            // transition is cancelled and out does not glitch.
            busy_d = 1'b0;
            cnt_d  = 8'd0;
        end else if (cnt_nxt >= dly) begin
            out_d  = tgt;
            busy_d = 1'b0;
            cnt_d  = 8'd0;
        end else begin
            busy_d = 1'b1;
            cnt_d  = cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= VX;
            busy_q <= 1'b0;
            cnt_q  <= 8'd0;
            pend_q <= VX;
        end else begin
            out_q  <= out_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign out    = out_q;
    assign busy   = busy_q;
    assign target = tgt;

endmodule

// File: tb/tb_cmos_pair_switch_model.sv
// ---------------------------------------------------------------------------
// Self-checking bench for cmos_pair_switch_model.
//
// Two instances share the same gate inputs:
//   u0 uses the default delays (5/5/5).
//   u1 uses RISE=2, FALL=7, ZX=3.
//
// A behavioural model keeps the run length of identical resolved targets
// sampled since reset. The node takes a new value once that value has been
// sampled for D consecutive edges.
// ---------------------------------------------------------------------------
module tb_cmos_pair_switch_model;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] pg, ng;
    logic [1:0] out0, out1, tgt0, tgt1;
    logic       busy0, busy1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cmos_pair_switch_model u0 (
        .clk(clk), .rst_n(rst_n), .pmos_g(pg), .nmos_g(ng),
        .out(out0), .busy(busy0), .target(tgt0)
    );

    cmos_pair_switch_model #(.RISE_DLY(8'd2), .FALL_DLY(8'd7), .ZX_DLY(8'd3)) u1 (
        .clk(clk), .rst_n(rst_n), .pmos_g(pg), .nmos_g(ng),
        .out(out1), .busy(busy1), .target(tgt1)
    );

    // ---------------- reference model ----------------
    int         DR [2] = '{5, 2};
    int         DF [2] = '{5, 7};
    int         DZ [2] = '{5, 3};
    logic [1:0] m_out  [2];
    logic       m_busy [2];
    logic [1:0] m_prev [2];
    int         m_run  [2];

    // Conduction code: 0 = off, 1 = on, 2 = unknown.
    function automatic logic [1:0] m_res(input logic [1:0] p, input logic [1:0] n);
        int pc, nc;
        pc = p[1] ? 2 : (p[0] ? 0 : 1);
        nc = n[1] ? 2 : (n[0] ? 1 : 0);
        if (pc == 2 || nc == 2 || (pc == 1 && nc == 1)) return 2'b11;
        if (pc == 1) return 2'b01;
        if (nc == 1) return 2'b00;
        return 2'b10;
    endfunction

    function automatic logic [1:0] m_tgt(input logic [1:0] p, input logic [1:0] n,
                                         input logic [1:0] cur);
        logic [1:0] r;
        r = m_res(p, n);
`ifdef CHARGE_HOLD_EN
        if (r == 2'b10) r = (cur == 2'b11) ? 2'b11 : cur;
`else
        if (r == 2'b10 && cur == 2'b10) r = 2'b10;
`endif
        return r;
    endfunction

    function automatic int m_dly(input int k, input logic [1:0] t);
        if (t == 2'b01) return DR[k];
        if (t == 2'b00) return DF[k];
        return DZ[k];
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_out[k]  = 2'b11;
            m_busy[k] = 1'b0;
            m_prev[k] = 2'b11;
            m_run[k]  = 0;
        end
    endtask

    task automatic m_edge();
        logic [1:0] t;
        for (int k = 0; k < 2; k++) begin
            t = m_tgt(pg, ng, m_out[k]);
            if (m_run[k] > 0 && t == m_prev[k]) m_run[k]++;
            else m_run[k] = 1;
            m_prev[k] = t;
            if (t != m_out[k] && m_run[k] >= m_dly(k, t)) m_out[k] = t;
            m_busy[k] = (t != m_out[k]);
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("out0",  out0,          m_out[0]);
        chk("busy0", {1'b0, busy0}, {1'b0, m_busy[0]});
        chk("tgt0",  tgt0,          m_tgt(pg, ng, m_out[0]));
        chk("out1",  out1,          m_out[1]);
        chk("busy1", {1'b0, busy1}, {1'b0, m_busy[1]});
        chk("tgt1",  tgt1,          m_tgt(pg, ng, m_out[1]));
    endtask

    // Advance one edge, then check at the following negedge.
    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            m_edge();
            @(negedge clk);
            cmp_model();
        end
    endtask

    task automatic set_in(input logic v);
        pg = {1'b0, v};
        ng = {1'b0, v};
    endtask

    // Async reset pulse placed between edges; called right after a negedge.
    task automatic rst_pulse();
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_out0",  out0,          2'b11);
        chk("rst_busy0", {1'b0, busy0}, 2'b00);
        chk("rst_out1",  out1,          2'b11);
        rst_n = 1'b1;
    endtask

    logic v;

    initial begin
        rst_n = 1'b0;
        pg = 2'b00;
        ng = 2'b00;
        m_reset();
        @(negedge clk);
        chk("reset_out0",  out0,          2'b11);
        chk("reset_busy0", {1'b0, busy0}, 2'b00);
        chk("reset_out1",  out1,          2'b11);
        chk("reset_busy1", {1'b0, busy1}, 2'b00);
        rst_n = 1'b1;

        // Inverter mode: establish out=0, then toggle every 200 cycles.
        set_in(1'b1);
        steps(10);
        chk("inv_init", out0, 2'b00);
        for (int k = 0; k < 4; k++) begin
            v = (k % 2 == 1);
            set_in(v);
            steps(4);
            chk("inv_hold", out0, {1'b0, v});
            chk("inv_busy", {1'b0, busy0}, 2'b01);
            steps(1);
            chk("inv_flip", out0, {1'b0, ~v});
            chk("inv_idle", {1'b0, busy0}, 2'b00);
            steps(195);
        end

        // Glitch rejection: out=0, in=0 for 3 cycles only.
        set_in(1'b0);
        steps(1);
        chk("gl_busy", {1'b0, busy0}, 2'b01);
        steps(2);
        chk("gl_out", out0, 2'b00);
        set_in(1'b1);
        steps(1);
        chk("gl_out_end",  out0,          2'b00);
        chk("gl_busy_end", {1'b0, busy0}, 2'b00);
        steps(10);
        chk("gl_out_late", out0, 2'b00);

        // Contention, then float.
        pg = 2'b00;
        ng = 2'b01;
        steps(4);
        chk("cont_pre", out0, 2'b00);
        steps(1);
        chk("cont_x", out0, 2'b11);
        pg = 2'b01;
        ng = 2'b00;
        steps(5);
`ifdef CHARGE_HOLD_EN
        chk("float", out0, 2'b11);
`else
        chk("float", out0, 2'b10);
`endif

        // Unknown gate gives X.
        set_in(1'b1);
        steps(10);
        pg = 2'b11;
        ng = 2'b00;
        steps(5);
        chk("unk_x", out0, 2'b11);

        // Asymmetric delays on u1.
        set_in(1'b1);
        steps(10);
        chk("u1_zero", out1, 2'b00);
        set_in(1'b0);
        steps(1);
        chk("u1_rise_pre", out1, 2'b00);
        steps(1);
        chk("u1_rise", out1, 2'b01);
        set_in(1'b1);
        steps(6);
        chk("u1_fall_pre", out1, 2'b01);
        steps(1);
        chk("u1_fall", out1, 2'b00);

        // Reset in the middle of a 0->1 transition.
        steps(5);
        set_in(1'b0);
        steps(3);
        chk("mid_busy", {1'b0, busy0}, 2'b01);
        rst_pulse();
        steps(4);
        chk("mid_pre", out0, 2'b11);
        steps(1);
        chk("mid_rise", out0, 2'b01);

        // Floating node after a driven 1.
        set_in(1'b0);
        steps(10);
        pg = 2'b01;
        ng = 2'b00;
        steps(50);
`ifdef CHARGE_HOLD_EN
        chk("hold_out",  out0,          2'b01);
        chk("hold_busy", {1'b0, busy0}, 2'b00);
`else
        chk("hold_out",  out0,          2'b10);
        chk("hold_busy", {1'b0, busy0}, 2'b00);
`endif

        // Randomised segments of random length, with occasional resets.
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 2) == 0) begin
                set_in(1'($urandom_range(0, 1)));
            end else begin
                pg = 2'($urandom_range(0, 3));
                ng = 2'($urandom_range(0, 3));
            end
            steps($urandom_range(1, 9));
            if ($urandom_range(0, 40) == 0) rst_pulse();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cmos_pair_switch_model.md
Name: cmos_pair_switch_model

Overview:
- Clocked, cycle-accurate model of one complementary MOS pair (PMOS pull-up to VDD, NMOS pull-down to VSS) sharing one output node.
- Resolves 4-valued gate inputs to a 4-valued node value.
- Applies an inertial propagation delay counted in clock cycles.
- Used as the leaf cell of the sampled-time switch-level simulator. With both gates tied together, it forms the sizing-characterisation inverter (delay 5).

Parameters:
- RISE_DLY, 5, cycles from a stable new target of 1 to out update (pull-up path; range 1..255).
- FALL_DLY, 5, cycles from a stable new target of 0 to out update (pull-down path; range 1..255).
- ZX_DLY, 5, cycles for a target of Z or X (range 1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- pmos_g  in  2  PMOS gate value: 00=0, 01=1, 10=Z, 11=X (same encoding on all value ports).
- nmos_g  in  2  NMOS gate value.
- out  out  2  node value, registered.
- busy  out  1  1 while a target differing from out is being timed.
- target  out  2  combinational resolved value (debug/observe).

Behaviour:
- Reset (rst_n=0, asynchronous): out=11 (X), busy=0, delay counter=0, pending target=X. Leaving reset is synchronous to the next clk edge.
- PMOS conduction: on if pmos_g=0; off if 1; unknown if Z or X.
- NMOS conduction: on if nmos_g=1; off if 0; unknown if Z or X.
- Resolution, combinational to target:
  - P on, N off -> 1.
  - P off, N on -> 0.
  - Both on -> X (contention).
  - Both off -> Z.
  - Any unknown -> X. Exception: P unknown with N on -> X, and N unknown with P on -> X (i.e. no strength-based L/H states; any unknown yields X).
- Delay per target: 1 -> RISE_DLY, 0 -> FALL_DLY, Z/X -> ZX_DLY.
- Inertial delay, per clk edge:
  - If target==out: counter cleared, busy=0.
  - Else if target differs from the pending target latched last cycle: latch it, counter=1, busy=1.
  - Else counter increments. When counter reaches the delay for that target, out<=target, counter cleared, busy=0.
  - Net latency: a target held stable for D cycles appears on out on the D-th edge after it first becomes sampled.
  - Pulses shorter than D are swallowed: out never shows them.
- A target change during timing restarts the count for the new value. A change back to out's value cancels the pending transition with no glitch.
- Reset asserted mid-transition aborts it immediately; out=X.
- Counter width is 8 bits; no wrap, since it saturates at compare.

Optional Feature:
- CHARGE_HOLD_EN defined: a resolved Z is treated as charge retention. Target becomes the last driven 0/1 held on the node, so out keeps its value, busy stays 0, and no Z is ever produced after a 0/1 has been driven. If out is X (after reset or contention), Z keeps out at X.
- Not defined: Z propagates to out after ZX_DLY as above.

Test Plan:
- Inverter mode: tie pmos_g=nmos_g=in; start from 0; toggle every 200 cycles. Required: out goes 1 five cycles after in=0 and 0 five cycles after in=1; busy is high for exactly those windows.
- Glitch rejection: in=1 stable with out=0; pulse in=0 for 3 cycles. Required: out stays 0, busy rises then falls, no change on out.
- Contention and float: pmos_g=0, nmos_g=1 -> out=X after 5 cycles. Then pmos_g=1, nmos_g=0 -> out=Z after 5 cycles (macro off), or out stays X (macro on).
- Unknown gate: pmos_g=X, nmos_g=0 -> out=X after ZX_DLY. With RISE_DLY=2, FALL_DLY=7: 0->1 takes 2 cycles and 1->0 takes 7 cycles.
- Reset mid-operation: during a pending 0->1 after 3 of 5 cycles, pulse rst_n low asynchronously. Required: out=X and busy=0 immediately; after release, out=1 five cycles later.
- Charge hold (CHARGE_HOLD_EN): drive out=1, then set pmos_g=1, nmos_g=0. Required: out remains 1 indefinitely and busy=0.
